// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_ACCESS, DMEM_RESPOND} state_e;
  typedef enum logic {OP_LOAD, OP_STORE} op_e;
  typedef struct packed {
    op_e op;
    logic both;
    logic oor;
    logic [WORD_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word storage with optional clear on reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (reset && INIT_ZERO) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we) mem_q[idx] <= wdata;
    if (re) rdata <= mem_q[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store responder that stalls the pipeline via busy.
// Defining DMEM_ACCESS_COUNT_EN adds load_count/store_count outputs.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  req_t req_q, req_d;
  logic [AW-1:0] idx_q, idx_d;
  logic zero_q, zero_d, accept, commit, we, re;
  logic [WORD_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q <= '0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      zero_q <= zero_d;
    end
    req_q <= req_d;
    idx_q <= idx_d;
  end

  // zero_q forces read_data to 0 after reset and after an out-of-range load
  always_comb begin
    accept = state_q == DMEM_IDLE && (mem_read || mem_write);
    commit = state_q == DMEM_ACCESS && cnt_q == '0;
    state_d = accept ? DMEM_ACCESS : commit ? DMEM_RESPOND :
              state_q == DMEM_ACCESS ? DMEM_ACCESS : DMEM_IDLE;
    cnt_d = accept ? LAT_W'(LATENCY - 1) : cnt_q - LAT_W'(cnt_q != '0);
    req_d = accept ? req_t'{op: mem_write ? OP_STORE : OP_LOAD, both: mem_read && mem_write,
                            oor: addr >= WORD_W'(DEPTH), wdata: write_data} : req_q;
    idx_d = accept ? addr[AW-1:0] : idx_q;
    we = commit && !reset && req_q.op == OP_STORE && !req_q.oor;
    re = commit && !reset && req_q.op == OP_LOAD && !req_q.oor;
    zero_d = commit && req_q.op == OP_LOAD ? req_q.oor : zero_q;
  end

  always_comb begin
    busy = accept || state_q == DMEM_ACCESS;
    read_valid = state_q == DMEM_RESPOND && req_q.op == OP_LOAD;
    err = state_q == DMEM_RESPOND && (req_q.oor || req_q.both);
    read_data = zero_q ? '0 : rdata;
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW), .INIT_ZERO(INIT_ZERO)) u_array (
    .clk(clk), .reset(reset), .we(we), .re(re), .idx(idx_q), .wdata(req_q.wdata), .rdata(rdata)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] load_count_q, load_count_d, store_count_q, store_count_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count_q <= '0;
      store_count_q <= '0;
    end else begin
      load_count_q <= load_count_d;
      store_count_q <= store_count_d;
    end
  end
  always_comb begin
    load_count_d = load_count_q + 32'(state_q == DMEM_RESPOND && req_q.op == OP_LOAD && !req_q.oor);
    store_count_d = store_count_q + 32'(state_q == DMEM_RESPOND && req_q.op == OP_STORE &&
                                         !req_q.oor && !req_q.both);
  end
  assign load_count = load_count_q;
  assign store_count = store_count_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (DEPTH=256, LATENCY=2, INIT_ZERO=0).
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset, mem_read, mem_write, read_valid, busy, err;
  logic [31:0] addr, write_data, read_data;
  logic [31:0] model [256];
  typedef struct {logic rv; logic er; logic [31:0] data;} resp_t;
  resp_t sb[$];
  int checks = 0, failures = 0;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] load_count, store_count;
  int exp_loads = 0, exp_stores = 0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .INIT_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .read_valid(read_valid), .busy(busy), .err(err)
`ifdef DMEM_ACCESS_COUNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (read_valid || err) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual rv=%b err=%b required no response", read_valid, err);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_rv", 32'(read_valid), 32'(e.rv));
        chk("resp_err", 32'(err), 32'(e.er));
        if (e.rv) chk("resp_data", read_data, e.data);
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    logic ld, bad;
    ld = r && !w;
    bad = (r && w) || a >= 256;
    if (ld || bad) sb.push_back('{ld, bad, (ld && a < 256) ? model[a[7:0]] : 32'h0});
    if (w && a < 256) model[a[7:0]] = d;
`ifdef DMEM_ACCESS_COUNT_EN
    if (ld && !bad) exp_loads++;
    if (w && !bad) exp_stores++;
`endif
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; write_data = d;
    #1;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
      addr = a ^ 32'hFF; write_data = ~d;
      #1;
    end
    chk("busy_cycles", 32'(n), 32'd3);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rv", 32'(read_valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_rdata", read_data, 0);
    op(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'd5, 32'h0);
    @(negedge clk); #1;
    chk("rdata_hold", read_data, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'd300, 32'h0);
    op(1'b1, 1'b1, 32'd7, 32'h12345678);
    op(1'b1, 1'b0, 32'd7, 32'h0);
    op(1'b1, 1'b0, 32'd5, 32'h0);
    op(1'b0, 1'b1, 32'd3, 32'h33);
    op(1'b0, 1'b1, 32'd259, 32'hBAD);
    op(1'b1, 1'b0, 32'd3, 32'h0);
    op(1'b0, 1'b1, 32'd255, 32'hCAFEF00D);
    op(1'b1, 1'b0, 32'd255, 32'h0);
    op(1'b0, 1'b1, 32'd9, 32'h11);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'd9; write_data = 32'hA5A5A5A5;
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", read_data, 0);
`ifdef DMEM_ACCESS_COUNT_EN
    exp_loads = 0; exp_stores = 0;
`endif
    op(1'b1, 1'b0, 32'd9, 32'h0);
    op(1'b1, 1'b0, 32'd256, 32'h0);
    op(1'b1, 1'b0, 32'd255, 32'h0);
    op(1'b0, 1'b1, 32'd4, 32'h44);
    repeat (2) @(negedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 0);
`ifdef DMEM_ACCESS_COUNT_EN
    chk("load_count", load_count, 32'(exp_loads));
    chk("store_count", store_count, 32'(exp_stores));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
